// File: rtl/pll_reconfig_ctrl_if.sv
// Control/status bundle for pll_reconfig_ctrl.
//   req        master->slave  one-cycle profile-change request
//   prof_sel   master->slave  requested profile index, sampled with req
//   sys_reset  slave->master  qualified downstream reset (low only while running)
//   busy       slave->master  a lock sequence is in progress
//   done       slave->master  one-cycle pulse on each entry to run
//   rej        slave->master  one-cycle pulse when req is refused
//   lock_lost  slave->master  one-cycle pulse when lock drops while running
//   fail       slave->master  retries exhausted; waits for a new req
//   cur_prof   slave->master  active profile index
interface pll_reconfig_ctrl_if #(
  parameter int unsigned PW = 2
) ();
  logic          req;
  logic [PW-1:0] prof_sel;
  logic          sys_reset;
  logic          busy;
  logic          done;
  logic          rej;
  logic          lock_lost;
  logic          fail;
  logic [PW-1:0] cur_prof;

  modport master (
    output req, prof_sel,
    input  sys_reset, busy, done, rej, lock_lost, fail, cur_prof
  );

  modport slave (
    input  req, prof_sel,
    output sys_reset, busy, done, rej, lock_lost, fail, cur_prof
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Runtime frequency-profile sequencer for a Gowin rPLL. Drives IDSEL/FBDSEL/ODSEL from a
// parameter table, runs reset-hold / lock-wait / lock-qualify with timeout and bounded
// retries, and produces a qualified downstream reset.
//   clk_i        PLL reference clock (CLKIN)
//   reset_i      asynchronous active-high reset
//   pll_lock_i   rPLL LOCK, asynchronous to clk_i
//   pll_reset_o  to rPLL RESET
//   idsel_o, fbdsel_o, odsel_o  registered divider codes to the rPLL
//   ctrl         request/status bundle (slave side)
module pll_reconfig_ctrl #(
  parameter int unsigned NUM_PROFILES        = 4,
  parameter logic [6*NUM_PROFILES-1:0] PROF_IDSEL  = {NUM_PROFILES{6'd60}},
  parameter logic [6*NUM_PROFILES-1:0] PROF_FBDSEL = {NUM_PROFILES{6'd63}},
  parameter logic [6*NUM_PROFILES-1:0] PROF_ODSEL  = {NUM_PROFILES{6'h30}},
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pll_lock_i,
  output logic               pll_reset_o,
  output logic [5:0]         idsel_o,
  output logic [5:0]         fbdsel_o,
  output logic [5:0]         odsel_o,
  pll_reconfig_ctrl_if.slave ctrl
);

  localparam int unsigned PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1;
  localparam int unsigned HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {StHold, StWaitLock, StStable, StRun, StFail} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [PW-1:0]   cur_prof_q, cur_prof_d;
  logic [5:0]      idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic            pll_reset_q, pll_reset_d, sys_reset_q, sys_reset_d;
  logic            busy_q, busy_d, done_q, done_d, rej_q, rej_d;
  logic            lock_lost_q, lock_lost_d, fail_q, fail_d;
  logic            lock_meta_q, lock_s_q;
  logic [5:0]      new_id, new_fb, new_od;
  logic [31:0]     sel_ext;
  logic            sel_ok, accept;

  assign sel_ext = 32'(ctrl.prof_sel);
  assign sel_ok  = sel_ext < NUM_PROFILES;
  assign accept  = ctrl.req && sel_ok && (state_q == StRun || state_q == StFail);

  // Table lookup by unrolled compare keeps every slice index constant.
  always_comb begin
    new_id = PROF_IDSEL[5:0];
    new_fb = PROF_FBDSEL[5:0];
    new_od = PROF_ODSEL[5:0];
    for (int i = 0; i < int'(NUM_PROFILES); i++) begin
      if (PW'(i) == ctrl.prof_sel) begin
        new_id = PROF_IDSEL[6*i +: 6];
        new_fb = PROF_FBDSEL[6*i +: 6];
        new_od = PROF_ODSEL[6*i +: 6];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    retry_d     = retry_q;
    cur_prof_d  = cur_prof_q;
    idsel_d     = idsel_q;
    fbdsel_d    = fbdsel_q;
    odsel_d     = odsel_q;
    lock_lost_d = 1'b0;
    rej_d       = ctrl.req && !accept;

    case (state_q)
      StHold: begin
        to_cnt_d   = '0;
        stab_cnt_d = '0;
        if (hold_cnt_q == HW'(RESET_HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = StWaitLock;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StWaitLock, StStable: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Timeout wins over lock detection and stable completion.
        if (to_cnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          to_cnt_d   = '0;
          stab_cnt_d = '0;
          hold_cnt_d = '0;
          retry_d    = retry_q + 1'b1;
          state_d    = (retry_d == RW'(MAX_RETRIES)) ? StFail : StHold;
        end else if (state_q == StWaitLock) begin
          if (lock_s_q) begin
            // The detecting cycle is the first qualified lock cycle.
            if (LOCK_STABLE_CYCLES == 1) begin
              stab_cnt_d = '0;
              state_d    = StRun;
            end else begin
              stab_cnt_d = SW'(1);
              state_d    = StStable;
            end
          end
        end else if (!lock_s_q) begin
          stab_cnt_d = '0;
          state_d    = StWaitLock;
        end else if (stab_cnt_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
          stab_cnt_d = '0;
          state_d    = StRun;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          lock_lost_d = 1'b1;
          retry_d     = '0;
          state_d     = StHold;
        end
      end
      StFail: ;
      default: state_d = StHold;
    endcase

    // An accepted request overrides everything, including a same-cycle lock drop.
    if (accept) begin
      state_d     = StHold;
      cur_prof_d  = ctrl.prof_sel;
      idsel_d     = new_id;
      fbdsel_d    = new_fb;
      odsel_d     = new_od;
      retry_d     = '0;
      hold_cnt_d  = '0;
      to_cnt_d    = '0;
      stab_cnt_d  = '0;
      lock_lost_d = 1'b0;
    end

    pll_reset_d = (state_d == StHold) || (state_d == StFail);
    sys_reset_d = (state_d != StRun);
    busy_d      = !((state_d == StRun) || (state_d == StFail));
    fail_d      = (state_d == StFail);
    done_d      = (state_d == StRun) && (state_q != StRun);
    if (done_d) retry_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      stab_cnt_q  <= '0;
      retry_q     <= '0;
      cur_prof_q  <= '0;
      idsel_q     <= PROF_IDSEL[5:0];
      fbdsel_q    <= PROF_FBDSEL[5:0];
      odsel_q     <= PROF_ODSEL[5:0];
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      retry_q     <= retry_d;
      cur_prof_q  <= cur_prof_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rej_q       <= rej_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset_o    = pll_reset_q;
  assign idsel_o        = idsel_q;
  assign fbdsel_o       = fbdsel_q;
  assign odsel_o        = odsel_q;
  assign ctrl.sys_reset = sys_reset_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.rej       = rej_q;
  assign ctrl.lock_lost = lock_lost_q;
  assign ctrl.fail      = fail_q;
  assign ctrl.cur_prof  = cur_prof_q;

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer that sits beside a Gowin rPLL and drives its dynamic IDSEL/FBDSEL/ODSEL inputs, so the output clock can be switched at runtime between a parameterised table of frequency profiles.
- Runs a reset-hold / lock-wait / lock-qualify sequence with timeout and bounded retries.
- Produces a qualified downstream reset and status.
- Runs in the PLL input-clock domain, between the board oscillator and the system reset tree.

Parameters:
- NUM_PROFILES, 4, number of selectable profiles (>=1); PW = max(1, clog2(NUM_PROFILES)).
- PROF_IDSEL, {NUM_PROFILES{6'd60}}, packed 6-bit IDSEL codes; profile i at bits [6i+5:6i]; 60 = ~IDIV 3.
- PROF_FBDSEL, {NUM_PROFILES{6'd63}}, packed 6-bit FBDSEL codes; 63 = ~FBDIV 0.
- PROF_ODSEL, {NUM_PROFILES{6'h30}}, packed 6-bit ODSEL codes; 6'h30 = /32.
- Default profile 0 gives 25 MHz from 100 MHz.
- RESET_HOLD_CYCLES, 16, cycles pll_reset is held per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 65536, cycles allowed from pll_reset release to qualified lock.
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised lock cycles needed to qualify lock.
- MAX_RETRIES, 3, timed-out attempts allowed before FAIL (>=1).

Ports:
- clk  in  1  PLL reference clock (CLKIN).
- reset  in  1  asynchronous, active-high.
- req  in  1  one-cycle profile-change request.
- prof_sel  in  PW  requested profile index, sampled with req.
- pll_lock  in  1  rPLL LOCK, asynchronous to clk.
- pll_reset  out  1  to rPLL RESET.
- idsel  out  6  to rPLL IDSEL.
- fbdsel  out  6  to rPLL FBDSEL.
- odsel  out  6  to rPLL ODSEL.
- sys_reset  out  1  active-high downstream reset; low only in RUN.
- busy  out  1  high in every state except RUN and FAIL.
- done  out  1  one-cycle pulse on each entry to RUN.
- rej  out  1  one-cycle pulse when req is rejected.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- fail  out  1  high while in FAIL.
- cur_prof  out  PW  active profile index.

Behaviour:
- Reset values (asynchronous, all registers): state=HOLD, cur_prof=0, idsel/fbdsel/odsel = profile 0 codes, pll_reset=1, sys_reset=1, busy=1, done=0, rej=0, lock_lost=0, fail=0, retry count=0, all counters=0.
- pll_lock passes through a 2-FF synchroniser (lock_s) with 2-cycle latency. Only lock_s is used.
- Selector outputs are registered. They change only on HOLD entry, when pll_reset is already 1 or goes to 1 in the same cycle.
- HOLD:
  - pll_reset=1 for exactly RESET_HOLD_CYCLES cycles, then go to WAIT_LOCK.
  - The timeout counter clears on HOLD entry.
- WAIT_LOCK:
  - pll_reset=0; the timeout counter increments each cycle.
  - lock_s=1 -> STABLE.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES -> retry+1. If retry == MAX_RETRIES, go to FAIL; otherwise go to HOLD with the same profile.
- STABLE:
  - The timeout counter keeps running; the stable counter increments while lock_s=1.
  - lock_s=0 -> clear stable counter, return to WAIT_LOCK.
  - Stable counter reaching LOCK_STABLE_CYCLES -> RUN.
  - Timeout expiry here is handled as in WAIT_LOCK; timeout has priority over stable completion in the same cycle.
- RUN:
  - On entry: sys_reset=0, done pulses, retry count clears.
  - lock_s=0 -> lock_lost pulse, sys_reset=1 next cycle, go to HOLD with the same profile and retry=0.
- FAIL: pll_reset=1, sys_reset=1, fail=1. Leaves only on an accepted req.
- req acceptance:
  - Accepted only in RUN or FAIL with prof_sel < NUM_PROFILES.
  - On the next cycle: cur_prof=prof_sel, new codes loaded, state=HOLD, sys_reset=1, busy=1, fail=0, retry=0.
  - Reselecting the current profile is legal and performs a full re-lock.
- req rejection:
  - req while busy, or with prof_sel >= NUM_PROFILES, pulses rej and changes nothing else.
- Simultaneous events:
  - req and lock drop in the same RUN cycle: req wins; lock_lost does not pulse.
- Reset mid-sequence: returns immediately to reset values; profile 0 is restored regardless of the prior cur_prof.

Test Plan:
- Sim params: RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, NUM_PROFILES=4.
- Power-up: release reset, raise pll_lock at cycle 10 -> pll_reset low after 4 cycles; sys_reset falls and done pulses 2+8 cycles after the lock rise (sync plus qualify); idsel=60, odsel=6'h30, cur_prof=0.
- Profile switch: in RUN, req with prof_sel=2 -> next cycle sys_reset=1, pll_reset=1, codes equal profile 2 and stay stable through HOLD; relock -> done, cur_prof=2.
- Glitchy lock: lock high 5 cycles, low 1, high -> stable counter restarts; RUN reached only after 8 consecutive synchronised high cycles.
- Timeout/retry: pll_lock held 0 -> two HOLD/WAIT_LOCK attempts of 4+32 cycles each, then fail=1 and pll_reset=1; req with prof_sel=1 -> recovers and reaches RUN.
- Rejections: req while busy, and req with prof_sel=3 while NUM_PROFILES=3 -> rej pulses; state, cur_prof and codes unchanged.
- Lock loss and mid-operation reset: drop lock in RUN -> lock_lost pulse, sys_reset=1, re-lock with the same profile; assert reset during WAIT_LOCK with cur_prof=2 -> all outputs return to reset values and cur_prof=0.
